// File: rtl/go_done_pkg.sv
// Shared definitions for both ends of the four-phase go/done handshake:
// initiator and responder state encodings and the 12 MHz default timeout.
package go_done_pkg;

  localparam int STATE_W = 2;

  // Initiator states
  localparam logic [STATE_W-1:0] IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ASSERT  = 2'd1;
  localparam logic [STATE_W-1:0] RELEASE = 2'd2;
  localparam logic [STATE_W-1:0] ERROR   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = IDLE,
    ST_ASSERT  = ASSERT,
    ST_RELEASE = RELEASE,
    ST_ERROR   = ERROR
  } init_state_t;

  // Responder states (used by the slow-clock processing blocks)
  localparam logic [STATE_W-1:0] RSP_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] RSP_WORK  = 2'd1;
  localparam logic [STATE_W-1:0] RSP_DONE  = 2'd2;
  localparam logic [STATE_W-1:0] RSP_WAIT  = 2'd3;

  // One second at 12 MHz, counted from zero
  localparam int unsigned TIMEOUT_MAX_12MHZ = 32'd12000000 - 32'd1;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit flip-flop synchroniser for a signal arriving from another clock
// domain. STAGES is the number of flops between d and q (2 or more).
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/go_done_initiator.sv
// Requester side of the four-phase go/done handshake with per-phase timeout
// supervision and a wrapping completed-transaction counter.
// Optional build macro GO_DONE_AUTO_REPEAT_EN: when defined, a held req level
// starts transactions back-to-back; otherwise only a req rising edge starts one.
module go_done_initiator
  import go_done_pkg::*;
#(
  parameter int          TIMEOUT_WIDTH = 24,
  parameter int unsigned TIMEOUT_MAX   = TIMEOUT_MAX_12MHZ,
  parameter int          SYNC_STAGES   = 2,
  parameter int          COUNT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   done_in,
  output logic                   go,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [COUNT_WIDTH-1:0] tx_count
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMAX = TIMEOUT_WIDTH'(TIMEOUT_MAX);

  init_state_t              r_state;
  init_state_t              w_state_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_timer;
  logic [COUNT_WIDTH-1:0]   r_tx_count;
  logic                     r_req_d;
  logic                     r_go;
  logic                     r_timeout_err;
  logic                     w_done_s;
  logic                     w_req_rise;
  logic                     w_start;
  logic                     w_timed_out;
  logic                     w_complete;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (done_in),
    .q   (w_done_s)
  );

  assign w_req_rise  = req & ~r_req_d;
  assign w_timed_out = (r_timer == TMAX);

`ifdef GO_DONE_AUTO_REPEAT_EN
  assign w_start = req & ~w_done_s;
`else
  assign w_start = w_req_rise & ~w_done_s;
`endif

  // Remember last req level so a rising edge can be detected
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d <= 1'b0;
    end else begin
      r_req_d <= req;
    end
  end

  // Next-state logic; a done transition takes priority over a timeout
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_ASSERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (w_done_s) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_timed_out) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_RELEASE: begin
        if (!w_done_s) begin
          w_state_nxt = ST_IDLE;
          w_complete  = 1'b1;
        end else if (w_timed_out) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_ERROR: begin
        if (!w_done_s && !req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ERROR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with registered go/timeout_err derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_go          <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_go          <= (w_state_nxt == ST_ASSERT);
      r_timeout_err <= (w_state_nxt == ST_ERROR);
    end
  end

  // Per-phase timer: cleared on state change, saturating count in active phases
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if ((r_state == ST_ASSERT) || (r_state == ST_RELEASE)) begin
      if (!w_timed_out) begin
        r_timer <= r_timer + TIMEOUT_WIDTH'(1);
      end else begin
        r_timer <= r_timer;
      end
    end else begin
      r_timer <= '0;
    end
  end

  // Completed-transaction counter, wraps naturally at 2^COUNT_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_count <= '0;
    end else if (w_complete) begin
      r_tx_count <= r_tx_count + COUNT_WIDTH'(1);
    end else begin
      r_tx_count <= r_tx_count;
    end
  end

  assign go          = r_go;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign tx_count    = r_tx_count;

endmodule

// File: tb/tb_go_done_initiator.sv
// Scoreboard bench for go_done_initiator: the stimulus thread pushes each
// expected output snapshot together with the clock edge it must appear on;
// a monitor pops and compares every time the DUT outputs change.
module tb_go_done_initiator;

  logic       clk;
  logic       rst;
  logic       req;
  logic       done_in;
  logic       go;
  logic       busy;
  logic       timeout_err;
  logic [3:0] tx_count;

  go_done_initiator #(
    .TIMEOUT_WIDTH (24),
    .TIMEOUT_MAX   (15),
    .SYNC_STAGES   (2),
    .COUNT_WIDTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done_in     (done_in),
    .go          (go),
    .busy        (busy),
    .timeout_err (timeout_err),
    .tx_count    (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] snap;
    int         at;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] last_exp = 7'd0;
  logic [6:0] prev_snap = 7'd0;
  logic       mon_en = 1'b0;
  logic [3:0] exp_cnt = 4'd0;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [6:0] mk(input logic g, input logic b, input logic e, input logic [3:0] c);
    return {g, b, e, c};
  endfunction

  function automatic logic [6:0] cur_snap();
    return {go, busy, timeout_err, tx_count};
  endfunction

  // Record an expected output change due at edge number 'at'
  task automatic push_exp(input logic [6:0] s, input int at);
    if (s !== last_exp) begin
      exp_t e;
      e.snap = s;
      e.at   = at;
      sb_q.push_back(e);
      last_exp = s;
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Direct comparison of the present outputs against the last expected snapshot
  task automatic check_now(input string name);
    logic [6:0] s;
    s = cur_snap();
    checks++;
    if (s !== last_exp) begin
      errors++;
      $display("FAIL %s: got go/busy/err/cnt=%b required %b at edge %0d", name, s, last_exp, cyc);
    end
  endtask

  // Monitor: each output change must match the next queued expectation and edge
  always @(negedge clk) begin
    if (mon_en) begin
      logic [6:0] s;
      s = cur_snap();
      if (s !== prev_snap) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b (was %b) at edge %0d, required no change", s, prev_snap, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (s !== e.snap || cyc != e.at) begin
            errors++;
            $display("FAIL sb_event: got %b at edge %0d required %b at edge %0d", s, cyc, e.snap, e.at);
          end
        end
        prev_snap = s;
      end
    end
  end

  // One full handshake with a prompt responder
  task automatic txn();
    int k;
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    adv(2);
    req = 1'b0;
    done_in = 1'b1;
    push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 5);
    adv(4);
    done_in = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 9);
    adv(4);
  endtask

  initial begin
    int k;
    int rc;
    rst = 1'b1;
    req = 1'b0;
    done_in = 1'b0;
    adv(2);
    rst = 1'b0;
    check_now("reset_state");
    mon_en = 1'b1;
    adv(2);

    // Basic handshake
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    adv(2);
    req = 1'b0;
    k = cyc;
    done_in = 1'b1;
    push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 3);
    adv(5);
    k = cyc;
    done_in = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 3);
    adv(6);
    check_now("basic_done");

    // Timeout in ASSERT; ERROR held while req stays high
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    push_exp(mk(1'b0, 1'b1, 1'b1, exp_cnt), k + 17);
    adv(20);
    req = 1'b0;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 21);
    adv(4);
    check_now("assert_timeout_recover");

    // done_s arrives in the same cycle the timer hits the limit: done wins
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    adv(2);
    req = 1'b0;
    adv(12);
    done_in = 1'b1;
    push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 17);
    adv(6);
    done_in = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 23);
    adv(5);
    check_now("priority_done");

    // Timeout in RELEASE; ERROR held until done_in drops
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    adv(3);
    done_in = 1'b1;
    req = 1'b0;
    push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 6);
    push_exp(mk(1'b0, 1'b1, 1'b1, exp_cnt), k + 22);
    adv(27);
    check_now("release_error_held");
    done_in = 1'b0;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 33);
    adv(5);
    check_now("release_timeout_recover");

    // Reset, then 16 transactions wrap the counter back to zero
    k = cyc;
    rst = 1'b1;
    exp_cnt = 4'd0;
    push_exp(mk(1'b0, 1'b0, 1'b0, 4'd0), k + 1);
    adv(2);
    rst = 1'b0;
    adv(2);
    for (int i = 0; i < 15; i++) txn();
    check_now("count_15");
    txn();
    check_now("count_wrap");

    // req edge while responder still reports done is ignored
    done_in = 1'b1;
    adv(4);
    req = 1'b1;
    adv(2);
    req = 1'b0;
    adv(2);
    done_in = 1'b0;
    adv(5);
    check_now("busy_ignore");

    // Reset during ASSERT aborts the transaction and clears the counter
    txn();
    k = cyc;
    req = 1'b1;
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    adv(3);
    rst = 1'b1;
    req = 1'b0;
    exp_cnt = 4'd0;
    push_exp(mk(1'b0, 1'b0, 1'b0, 4'd0), k + 4);
    adv(2);
    rst = 1'b0;
    adv(3);
    done_in = 1'b1;
    adv(6);
    done_in = 1'b0;
    adv(6);
    check_now("no_spurious_after_reset");

    // req held high with a responder answering 4 edges after go changes
    k = cyc;
    req = 1'b1;
`ifdef GO_DONE_AUTO_REPEAT_EN
    for (int j = 0; j < 3; j++) begin
      push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1 + 13 * j);
      push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 7 + 13 * j);
      exp_cnt = exp_cnt + 4'd1;
      push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 13 + 13 * j);
    end
`else
    push_exp(mk(1'b1, 1'b1, 1'b0, exp_cnt), k + 1);
    push_exp(mk(1'b0, 1'b1, 1'b0, exp_cnt), k + 7);
    exp_cnt = exp_cnt + 4'd1;
    push_exp(mk(1'b0, 1'b0, 1'b0, exp_cnt), k + 13);
`endif
    rc = 0;
    for (int i = 0; i < 50; i++) begin
      adv(1);
      if (go !== done_in) begin
        rc++;
        if (rc == 4) begin
          done_in = go;
          rc = 0;
        end
      end else begin
        rc = 0;
      end
      if (i == 30) req = 1'b0;
    end
    check_now("held_req_count");

    adv(5);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected changes, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
